// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply / restoring divide unit.
// Results go to HI/LO; done pulses once per operation, div0 flags a zero divisor.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             md_start,
    input  logic             md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int unsigned        ACC_W    = 2 * WIDTH;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_b_zero;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [ACC_W-1:0]   w_mul_acc;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [ACC_W-1:0]   w_div_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes and iteration bookkeeping
    always_comb begin
        w_abs_a  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        w_abs_b  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        w_b_zero = (b == '0);
        w_last   = (r_cnt == CNT_LAST);
    end

    // One shift-add / restoring-divide step on the 64-bit working register
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[ACC_W-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
        w_mul_acc  = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_ge   = (r_acc[ACC_W-1:WIDTH-1] >= {1'b0, r_mag_b});
        w_div_rem  = WIDTH'(r_acc[ACC_W-1:WIDTH-1] - {1'b0, r_mag_b});
        w_div_acc  = w_div_ge ? {w_div_rem, r_acc[WIDTH-2:0], 1'b1}
                              : {r_acc[ACC_W-2:0], 1'b0};
        w_acc_next = (r_state == S_MULT) ? w_mul_acc : w_div_acc;
    end

    // Sign correction of the final magnitude result
    always_comb begin
        w_prod_fix = r_neg_q ? (~w_acc_next + ACC_W'(1)) : w_acc_next;
        w_quot_fix = r_neg_q ? (~w_acc_next[WIDTH-1:0] + WIDTH'(1))
                             : w_acc_next[WIDTH-1:0];
        w_rem_fix  = r_neg_r ? (~w_acc_next[ACC_W-1:WIDTH] + WIDTH'(1))
                             : w_acc_next[ACC_W-1:WIDTH];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (md_start) begin
                    if (!md_op)        w_state_next = S_MULT;
                    else if (w_b_zero) w_state_next = S_DONE;
                    else               w_state_next = S_DIV;
                end
            end
            S_MULT,
            S_DIV:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath, result registers and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_MULT) || (w_state_next == S_DIV);
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        r_cnt   <= '0;
                        r_mag_a <= w_abs_a;
                        r_mag_b <= w_abs_b;
                        r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r <= a[WIDTH-1];
                        r_div0  <= md_op && w_b_zero;
                        r_acc   <= {{WIDTH{1'b0}}, (md_op ? w_abs_a : w_abs_b)};
                    end
                end
                S_MULT,
                S_DIV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        if (r_state == S_MULT) begin
                            r_hi <= w_prod_fix[ACC_W-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table vectors, corner sequences and random ops vs. arithmetic model.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        md_start;
    logic        md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .md_start(md_start), .md_op(md_op),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Results captured by run_op
    logic [31:0] cap_hi, cap_lo;
    logic        cap_div0, end_div0;
    int          lat, nbusy, ndone;

    // Model state: expected HI/LO carried between operations
    logic [31:0] m_hi, m_lo;
    logic [31:0] e_hi, e_lo;
    logic        e_div0;
    int          e_lat;

    typedef struct {
        logic        op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] x_hi;
        logic [31:0] x_lo;
        logic        x_div0;
        int          x_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one op and observe a fixed 40-cycle window; optional stray start at cycle pulse_at
    task automatic run_op(input logic op, input logic [31:0] ia, input logic [31:0] ib,
                          input int pulse_at);
        md_op = op; a = ia; b = ib; md_start = 1'b1;
        @(posedge clock); #1;
        md_start = 1'b0;
        a = $urandom; b = $urandom; md_op = 1'($urandom_range(0, 1));
        lat = 0; nbusy = 0; ndone = 0;
        cap_hi = 'x; cap_lo = 'x; cap_div0 = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            if (busy) nbusy++;
            if (done) begin
                if (ndone == 0) begin
                    lat = k; cap_hi = hi; cap_lo = lo; cap_div0 = div0;
                end
                ndone++;
            end
            md_start = (k == pulse_at);
            @(posedge clock); #1;
        end
        md_start = 1'b0;
        end_div0 = div0;
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    task automatic model(input logic op, input logic [31:0] ia, input logic [31:0] ib);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        e_div0 = 1'b0;
        e_lat  = 33;
        if (!op) begin
            p = 64'(sa * sb);
            e_hi = p[63:32];
            e_lo = p[31:0];
        end else if (ib == 32'd0) begin
            e_div0 = 1'b1;
            e_lat  = 1;
            e_hi   = m_hi;
            e_lo   = m_lo;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e_lo = 32'(q);
            e_hi = 32'(r);
        end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1] = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[2] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3] = '{1'b1, 32'd100,        32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[4] = '{1'b1, 32'd100,        32'd0,        32'd2,        32'd14,       1'b1, 1};
        vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[7] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 33};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
        vecs[9] = '{1'b0, 32'd0,          32'h12345678, 32'd0,        32'd0,        1'b0, 33};

        reset = 1'b1; md_start = 1'b0; md_op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div0", 64'(div0), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Table vectors; vector 5 carries a stray start at cycle 10 that must be ignored
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].va, vecs[i].vb, (i == 5) ? 10 : 0);
            chk($sformatf("vec%0d_hi", i),    64'(cap_hi),   64'(vecs[i].x_hi));
            chk($sformatf("vec%0d_lo", i),    64'(cap_lo),   64'(vecs[i].x_lo));
            chk($sformatf("vec%0d_div0", i),  64'(cap_div0), 64'(vecs[i].x_div0));
            chk($sformatf("vec%0d_lat", i),   64'(lat),      64'(vecs[i].x_lat));
            chk($sformatf("vec%0d_ndone", i), 64'(ndone),    64'd1);
            chk($sformatf("vec%0d_nbusy", i), 64'(nbusy),    (vecs[i].x_lat == 1) ? 64'd0 : 64'd32);
            chk($sformatf("vec%0d_div0_end", i), 64'(end_div0), 64'(vecs[i].x_div0));
        end

        // Asynchronous reset in the middle of a multiply
        md_op = 1'b0; a = 32'd12345; b = 32'd6789; md_start = 1'b1;
        @(posedge clock); #1;
        md_start = 1'b0;
        repeat (12) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_hi",   64'(hi),   64'd0);
        chk("rst_mid_lo",   64'(lo),   64'd0);
        @(posedge clock); #3;
        reset = 1'b0;
        ndone = 0; nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("rst_after_ndone", 64'(ndone), 64'd0);
        chk("rst_after_nbusy", 64'(nbusy), 64'd0);
        chk("rst_after_hi",    64'(hi),    64'd0);
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 0);
        chk("rst_new_hi",  64'(cap_hi), 64'hFFFFFFFF);
        chk("rst_new_lo",  64'(cap_lo), 64'hFFFFFFEB);
        chk("rst_new_lat", 64'(lat),    64'd33);

        // Randomized operations against the arithmetic model
        m_hi = 32'hFFFFFFFF;
        m_lo = 32'hFFFFFFEB;
        for (int i = 0; i < 150; i++) begin
            logic        op;
            logic [31:0] ra, rb;
            int          sel;
            op = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'($urandom_range(0, 15)) - 32'd8;
            else if (sel == 2) rb = 32'h80000000;
            else if (sel == 3) ra = 32'h80000000;
            else if (sel == 4) ra = 32'($urandom_range(0, 255)) - 32'd128;
            model(op, ra, rb);
            run_op(op, ra, rb, 0);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, op, ra, rb), 64'(cap_hi), 64'(e_hi));
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, op, ra, rb), 64'(cap_lo), 64'(e_lo));
            chk($sformatf("rnd%0d_div0", i),  64'(cap_div0), 64'(e_div0));
            chk($sformatf("rnd%0d_lat", i),   64'(lat),      64'(e_lat));
            chk($sformatf("rnd%0d_ndone", i), 64'(ndone),    64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
